// File: rtl/raster_stream_pkg.sv
`default_nettype none
//============================================================================
// Module      : raster_stream_pkg
// Description : Shared definitions for the raster stream reader: FSM state
//               encoding, marker bit layout and a counter-width helper.
// Revision    : 1.0  initial release
//============================================================================
package raster_stream_pkg;

    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_FETCH = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN = 2'd2;

    // Marker bits ride above the pixel in the skid buffer: {sof, eol, eof}
    localparam int c_MK_W = 3;

    // Width able to hold 0..n-1 (never below 1 bit)
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid2.sv
`default_nettype none
//============================================================================
// Module      : stream_skid2
// Description : 2-entry FIFO with a registered head. Output side never
//               depends combinationally on out_ready; occupancy is exported
//               so the producer can credit its reads.
// Revision    : 1.0  initial release
// Ports       : clk, rst         clock, async active-high reset
//               in_valid/in_data/in_ready     write side
//               out_valid/out_data/out_ready  read side
//               occupancy        entries held (0..2)
//============================================================================
module stream_skid2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    occupancy
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [1:0]    r_occ;
    logic          w_push;
    logic          w_pop;

    assign w_pop     = (r_occ != 2'd0) & out_ready;
    assign in_ready  = (r_occ != 2'd2) | out_ready;
    assign w_push    = in_valid & in_ready;
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_head;
    assign occupancy = r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= in_data;
                    else               r_tail <= in_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop only occurs with 1 or 2 entries held
                    if (r_occ == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= in_data;
                    end else begin
                        r_head <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/raster_stream_reader.sv
`default_nettype none
//============================================================================
// Module      : raster_stream_reader
// Description : Reads one feature-map frame row-major from on-chip RAM and
//               emits it as a valid/ready pixel stream with sof/eol/eof.
//               Optional macro RASTER_STREAM_PAD_EN adds a 1-pixel zero
//               border on every side (no RAM read for border beats).
// Revision    : 1.0  initial release
// Ports       : clk, rst               clock, async active-high reset
//               start, base_addr       frame request (base sampled on accept)
//               busy, done             frame status, done is a 1-cycle pulse
//               mem_rd_en, mem_addr    RAM read request
//               mem_rdata              RAM data, 1 cycle after mem_rd_en
//               dout, valid_out, ready_in   pixel stream handshake
//               sof, eol, eof          frame markers qualifying dout
//============================================================================
module raster_stream_reader
    import raster_stream_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    parameter int ADDR_W     = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [WIDTH-1:0]  dout,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              sof,
    output logic              eol,
    output logic              eof
);

    localparam int CNT_W = cnt_width(IMG_WIDTH + 2);
    localparam int ROW_W = cnt_width(IMG_HEIGHT + 2);
`ifdef RASTER_STREAM_PAD_EN
    localparam int c_OUT_W = IMG_WIDTH + 2;
    localparam int c_OUT_H = IMG_HEIGHT + 2;
`else
    localparam int c_OUT_W = IMG_WIDTH;
    localparam int c_OUT_H = IMG_HEIGHT;
`endif
    localparam logic [CNT_W-1:0] c_LAST_COL = CNT_W'(c_OUT_W - 1);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(c_OUT_H - 1);
    localparam int c_SKID_W = WIDTH + c_MK_W;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]     r_col;
    logic [ROW_W-1:0]     r_row;
    logic [ADDR_W-1:0]    r_ptr;
    logic                 r_infl;
    logic [c_MK_W-1:0]    r_infl_mk;
    logic                 r_done;

    logic [CNT_W-1:0]     w_cur_col;
    logic [ROW_W-1:0]     w_cur_row;
    logic [ADDR_W-1:0]    w_cur_addr;
    logic                 w_sof;
    logic                 w_eol;
    logic                 w_eof;
    logic                 w_pad;
    logic                 w_issue;
    logic                 w_pop;
    logic [2:0]           w_level;
    logic                 w_credit;
    logic [WIDTH-1:0]     w_push_pix;
    logic                 w_skid_in_ready;
    logic [c_SKID_W-1:0]  w_skid_out;
    logic [1:0]           w_occ;

    // In IDLE the first beat is issued in the same cycle start is accepted,
    // so the current position comes straight from (0,0)/base_addr.
    assign w_cur_col  = (r_state == c_ST_IDLE) ? '0 : r_col;
    assign w_cur_row  = (r_state == c_ST_IDLE) ? '0 : r_row;
    assign w_cur_addr = (r_state == c_ST_IDLE) ? base_addr : r_ptr;

    assign w_sof = (w_cur_col == '0) && (w_cur_row == '0);
    assign w_eol = (w_cur_col == c_LAST_COL);
    assign w_eof = w_eol && (w_cur_row == c_LAST_ROW);

`ifdef RASTER_STREAM_PAD_EN
    logic r_infl_pad;
    assign w_pad      = (w_cur_row == '0) || (w_cur_row == c_LAST_ROW) ||
                        (w_cur_col == '0) || w_eol;
    assign w_push_pix = r_infl_pad ? '0 : mem_rdata;
`else
    assign w_pad      = 1'b0;
    assign w_push_pix = mem_rdata;
`endif

    // Credit counts the slot freed by this cycle's pop so a steady stream
    // keeps one entry buffered and one read in flight (1 pixel/cycle).
    assign w_pop    = valid_out & ready_in;
    assign w_level  = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_credit = (w_level < 3'd2);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_issue     = 1'b1;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (w_eof) w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // The eof beat is the last thing in the buffer, so its
                // acceptance means the buffer is now empty.
                if (w_pop && w_skid_out[WIDTH]) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_ptr      <= '0;
            r_infl     <= 1'b0;
            r_infl_mk  <= '0;
            r_done     <= 1'b0;
`ifdef RASTER_STREAM_PAD_EN
            r_infl_pad <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= (r_state == c_ST_DRAIN) && w_pop && w_skid_out[WIDTH];
            r_infl     <= w_issue;
            r_infl_mk  <= {w_sof, w_eol, w_eof};
`ifdef RASTER_STREAM_PAD_EN
            r_infl_pad <= w_pad;
`endif
            if (w_issue) begin
                r_ptr <= w_pad ? w_cur_addr : (w_cur_addr + ADDR_W'(1));
                if (w_eol) begin
                    r_col <= '0;
                    r_row <= w_cur_row + ROW_W'(1);
                end else begin
                    r_col <= w_cur_col + CNT_W'(1);
                    r_row <= w_cur_row;
                end
            end
        end
    end

    // Crediting guarantees the buffer always has room for a returning beat.
    always @(posedge clk) begin
        if (!rst && r_infl) assert (w_skid_in_ready);
    end

    stream_skid2 #(
        .DW(c_SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_infl),
        .in_data   ({r_infl_mk, w_push_pix}),
        .in_ready  (w_skid_in_ready),
        .out_valid (valid_out),
        .out_data  (w_skid_out),
        .out_ready (ready_in),
        .occupancy (w_occ)
    );

    assign dout      = w_skid_out[WIDTH-1:0];
    assign sof       = w_skid_out[WIDTH+2];
    assign eol       = w_skid_out[WIDTH+1];
    assign eof       = w_skid_out[WIDTH];
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;
    assign mem_rd_en = w_issue & ~w_pad;
    assign mem_addr  = mem_rd_en ? w_cur_addr : '0;

endmodule
`default_nettype wire
